// File: rtl/roi_pkg.sv
// Shared types and constants for the AXI4-Stream ROI cropper.
package roi_pkg;

    localparam int X_LSB = 16;
    localparam int Y_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } roi_state_t;

    // Coordinates never exceed 16 bits because of the 16-bit packing in xy_*_i.
    typedef struct packed {
        logic [15:0] xl;
        logic [15:0] xr;
        logic [15:0] yt;
        logic [15:0] yb;
    } roi_rect_t;

    function automatic int roi_cw(input int w, input int h);
        return $clog2((w > h) ? w : h);
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI4-Stream register; the slot accepts whenever it is empty or draining.
module axis_reg_slice #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    assign in_ready = !out_valid || out_ready;

    // Output slot: load on every free cycle, hold while stalled.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/roi_axis_crop.sv
// AXI4-Stream ROI cropper: forwards pixels inside a per-frame latched rectangle.
// Optional ROI_STATS_EN adds roi_cnt_o, the forwarded-pixel count of the current frame.
module roi_axis_crop
    import roi_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int MAX_W  = 1024,
    parameter  int MAX_H  = 1024,
    localparam int CW     = roi_cw(MAX_W, MAX_H)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] s_tdata_i,
    input  logic              s_tvalid_i,
    output logic              s_tready_o,
    input  logic              s_tuser_i,
    input  logic              s_tlast_i,
    input  logic [CW-1:0]     frame_w_i,
    input  logic [CW-1:0]     frame_h_i,
    input  logic [31:0]       xy_0_i,
    input  logic [31:0]       xy_1_i,
    input  logic              line_mode_i,
    output logic [DATA_W-1:0] m_tdata_o,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic              m_tuser_o,
    output logic              m_tlast_o,
    output logic              cfg_err_o,
    output logic              line_err_o,
`ifdef ROI_STATS_EN
    output logic [$clog2(MAX_W*MAX_H+1)-1:0] roi_cnt_o,
`endif
    output logic              frame_done_o
);

    roi_state_t      state_r;
    roi_rect_t       rect_r, new_rect_s, cur_rect_s;
    logic [CW-1:0]   cx_r, cy_r, fw_r, fh_r;
    logic [CW-1:0]   x0_s, y0_s, x1_s, y1_s;
    logic [CW-1:0]   cur_x_s, cur_y_s, cur_fw_s, cur_fh_s;
    logic            lm_r, cur_lm_s, eof_r;
    logic            beat_s, sof_s, proc_s, cfg_bad_s, in_roi_s, fwd_s;
    logic            at_xl_s, at_xr_s, at_yt_s, at_yb_s;
    logic            pix_user_s, pix_last_s, pix_eof_s, line_err_s, eof_line_s;
    logic [DATA_W+1:0] slice_out_s;
    logic            unused_s;

    assign x0_s = xy_0_i[X_LSB +: CW];
    assign y0_s = xy_0_i[Y_LSB +: CW];
    assign x1_s = xy_1_i[X_LSB +: CW];
    assign y1_s = xy_1_i[Y_LSB +: CW];
    assign unused_s = ^{xy_0_i, xy_1_i};

    // On an SOF beat the fresh configuration and (0,0) apply to that very beat.
    always_comb begin
        new_rect_s.xl = 16'((x0_s < x1_s) ? x0_s : x1_s);
        new_rect_s.xr = 16'((x0_s < x1_s) ? x1_s : x0_s);
        new_rect_s.yt = 16'((y0_s < y1_s) ? y0_s : y1_s);
        new_rect_s.yb = 16'((y0_s < y1_s) ? y1_s : y0_s);
        cfg_bad_s  = (new_rect_s.xr > 16'(frame_w_i)) || (new_rect_s.yb > 16'(frame_h_i)) ||
                     (int'(frame_w_i) > MAX_W - 1) || (int'(frame_h_i) > MAX_H - 1);
        beat_s     = s_tvalid_i && s_tready_o;
        sof_s      = beat_s && s_tuser_i;
        proc_s     = beat_s && (sof_s || (state_r != IDLE));
        cur_rect_s = sof_s ? new_rect_s  : rect_r;
        cur_x_s    = sof_s ? '0          : cx_r;
        cur_y_s    = sof_s ? '0          : cy_r;
        cur_fw_s   = sof_s ? frame_w_i   : fw_r;
        cur_fh_s   = sof_s ? frame_h_i   : fh_r;
        cur_lm_s   = sof_s ? line_mode_i : lm_r;
        at_xl_s    = 16'(cur_x_s) == cur_rect_s.xl;
        at_xr_s    = 16'(cur_x_s) == cur_rect_s.xr;
        at_yt_s    = 16'(cur_y_s) == cur_rect_s.yt;
        at_yb_s    = 16'(cur_y_s) == cur_rect_s.yb;
        in_roi_s   = (16'(cur_x_s) >= cur_rect_s.xl) && (16'(cur_x_s) <= cur_rect_s.xr) &&
                     (16'(cur_y_s) >= cur_rect_s.yt) && (16'(cur_y_s) <= cur_rect_s.yb);
        if (sof_s) begin
            fwd_s = proc_s && !cfg_bad_s && in_roi_s;
        end else begin
            fwd_s = proc_s && (state_r == ACTIVE) && in_roi_s;
        end
        pix_user_s = at_xl_s && at_yt_s;
        pix_eof_s  = at_xr_s && at_yb_s;
        pix_last_s = cur_lm_s ? at_xr_s : pix_eof_s;
        line_err_s = proc_s && ((s_tlast_i != (cur_x_s == cur_fw_s)) ||
                                (sof_s && (state_r != IDLE)));
        eof_line_s = s_tlast_i && (cur_y_s == cur_fh_s);
    end

    // Frame FSM, raster counters and error pulses; lines realign on s_tlast_i.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_r    <= IDLE;
            rect_r     <= '0;
            cx_r       <= '0;
            cy_r       <= '0;
            fw_r       <= '0;
            fh_r       <= '0;
            lm_r       <= 1'b0;
            eof_r      <= 1'b0;
            cfg_err_o  <= 1'b0;
            line_err_o <= 1'b0;
        end else begin
            cfg_err_o  <= sof_s && cfg_bad_s;
            line_err_o <= line_err_s;
            if (sof_s) begin
                rect_r  <= new_rect_s;
                fw_r    <= frame_w_i;
                fh_r    <= frame_h_i;
                lm_r    <= line_mode_i;
                state_r <= cfg_bad_s ? DROP : ACTIVE;
            end
            if (proc_s) begin
                if (s_tlast_i) begin
                    cx_r <= '0;
                    cy_r <= eof_line_s ? '0 : cur_y_s + 1'b1;
                    if (eof_line_s) begin
                        state_r <= IDLE;
                    end
                end else begin
                    cx_r <= cur_x_s + 1'b1;
                    cy_r <= cur_y_s;
                end
            end
            // eof_r tracks whether the beat in the output slot is the frame's final ROI pixel.
            if (s_tready_o) begin
                eof_r <= fwd_s && pix_eof_s;
            end
        end
    end

    axis_reg_slice #(.W(DATA_W + 2)) u_out (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .in_data   ({pix_user_s, pix_last_s, s_tdata_i}),
        .in_valid  (fwd_s),
        .in_ready  (s_tready_o),
        .out_data  (slice_out_s),
        .out_valid (m_tvalid_o),
        .out_ready (m_tready_i)
    );

    assign {m_tuser_o, m_tlast_o, m_tdata_o} = slice_out_s;
    assign frame_done_o = m_tvalid_o && m_tready_i && eof_r;

`ifdef ROI_STATS_EN
    // Forwarded-pixel count, restarted by every SOF beat and held between frames.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            roi_cnt_o <= '0;
        end else if (sof_s) begin
            roi_cnt_o <= fwd_s ? ($clog2(MAX_W*MAX_H+1))'(1) : '0;
        end else if (fwd_s) begin
            roi_cnt_o <= roi_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_roi_axis_crop.sv
// Directed bench for roi_axis_crop with a raster-level reference model and scoreboard.
`timescale 1ns/1ps
module tb_roi_axis_crop;

    logic        clk_i = 1'b0;
    logic        arst_i = 1'b1;
    logic [7:0]  s_tdata_i = 8'd0;
    logic        s_tvalid_i = 1'b0, s_tuser_i = 1'b0, s_tlast_i = 1'b0;
    logic        s_tready_o;
    logic [9:0]  frame_w_i = 10'd0, frame_h_i = 10'd0;
    logic [31:0] xy_0_i = 32'd0, xy_1_i = 32'd0;
    logic        line_mode_i = 1'b0;
    logic [7:0]  m_tdata_o;
    logic        m_tvalid_o, m_tuser_o, m_tlast_o;
    logic        m_tready_i = 1'b1;
    logic        cfg_err_o, line_err_o, frame_done_o;

    int total = 0, bad = 0;
    int exp_cfg = 0, exp_line = 0, exp_done = 0;
    int got_cfg = 0, got_line = 0, got_done = 0;
    logic rnd_ready = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] out_log[$];

    roi_axis_crop dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
        .s_tuser_i(s_tuser_i), .s_tlast_i(s_tlast_i),
        .frame_w_i(frame_w_i), .frame_h_i(frame_h_i),
        .xy_0_i(xy_0_i), .xy_1_i(xy_1_i), .line_mode_i(line_mode_i),
        .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
        .m_tuser_o(m_tuser_o), .m_tlast_o(m_tlast_o),
        .cfg_err_o(cfg_err_o), .line_err_o(line_err_o), .frame_done_o(frame_done_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Downstream ready: constant or pseudo-random, changed on the falling edge.
    initial forever begin
        @(negedge clk_i);
        m_tready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: samples 1 ns before each rising edge.
    initial begin
        logic       stall_prev;
        logic [9:0] pay, prev_pay;
        stall_prev = 1'b0;
        prev_pay   = 10'd0;
        forever begin
            @(negedge clk_i);
            #4;
            pay = {m_tuser_o, m_tlast_o, m_tdata_o};
            if (arst_i) begin
                stall_prev = 1'b0;
            end else begin
                check("s_tready", 32'(s_tready_o), 32'(!m_tvalid_o || m_tready_i));
                if (stall_prev) begin
                    check("stall_hold", {21'd0, m_tvalid_o, pay}, {21'd0, 1'b1, prev_pay});
                end
                if (m_tvalid_o && m_tready_i) begin
                    out_log.push_back(pay);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_beat: got %0h, expected no beat", pay);
                    end else begin
                        check("pixel", 32'(pay), 32'(exp_q.pop_front()));
                    end
                end
                got_cfg  += int'(cfg_err_o);
                got_line += int'(line_err_o);
                got_done += int'(frame_done_o);
                stall_prev = m_tvalid_o && !m_tready_i;
                prev_pay   = pay;
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
        int n;
        n = 0;
        @(negedge clk_i);
        s_tdata_i = d; s_tuser_i = u; s_tlast_i = l; s_tvalid_i = 1'b1;
        forever begin
            #4;
            if (s_tready_o) break;
            n++;
            if (n > 1000) begin
                total++;
                bad++;
                $display("FAIL input_timeout: got s_tready_o=0, expected 1 within 1000 cycles");
                break;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk_i);
        s_tvalid_i = 1'b0; s_tuser_i = 1'b0; s_tlast_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    // Reference model: raster position of each generated beat decides its fate.
    task automatic run_frame(input int fw, input int fh, input int x0, input int y0,
                             input int x1, input int y1, input logic lm, input logic [7:0] seed,
                             input int short_y, input int short_len, input int cut);
        int xl, xr, yt, yb, len, sent;
        logic cfg_bad;
        logic [7:0] d;
        xl = (x0 < x1) ? x0 : x1;  xr = (x0 < x1) ? x1 : x0;
        yt = (y0 < y1) ? y0 : y1;  yb = (y0 < y1) ? y1 : y0;
        cfg_bad = (xr > fw) || (yb > fh);
        frame_w_i = 10'(fw); frame_h_i = 10'(fh); line_mode_i = lm;
        xy_0_i = (32'(x0) << 16) | 32'(y0);
        xy_1_i = (32'(x1) << 16) | 32'(y1);
        if (cfg_bad) exp_cfg++;
        sent = 0;
        for (int y = 0; y <= fh; y++) begin
            len = (y == short_y) ? short_len : fw + 1;
            for (int x = 0; x < len; x++) begin
                if (cut >= 0 && sent == cut) return;
                d = 8'(y * 16 + x) ^ seed;
                if (!cfg_bad && x >= xl && x <= xr && y >= yt && y <= yb)
                    exp_q.push_back({x == xl && y == yt, lm ? (x == xr) : (x == xr && y == yb), d});
                if (!cfg_bad && x == xr && y == yb) exp_done++;
                if (x == len - 1 && len != fw + 1) exp_line++;
                send_beat(d, x == 0 && y == 0, x == len - 1);
                sent++;
            end
        end
    endtask

    task automatic finish_test(input string tag);
        rnd_ready = 1'b0;
        idle(10);
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_cfg_err"}, 32'(got_cfg), 32'(exp_cfg));
        check({tag, "_line_err"}, 32'(got_line), 32'(exp_line));
        check({tag, "_done"}, 32'(got_done), 32'(exp_done));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 32'(m_tvalid_o), 32'd0);
        check({tag, "_payload"}, {22'd0, m_tuser_o, m_tlast_o, m_tdata_o}, 32'd0);
        check({tag, "_errs"}, {30'd0, cfg_err_o, line_err_o}, 32'd0);
        check({tag, "_done"}, 32'(frame_done_o), 32'd0);
        check({tag, "_tready"}, 32'(s_tready_o), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        #4;
        check_reset_outputs("rst_in");
        @(negedge clk_i);
        arst_i = 1'b0;
        #4;
        check_reset_outputs("rst_out");

        // 1: frame mode, ROI (2,1)-(4,3)
        out_log.delete();
        run_frame(7, 5, 2, 1, 4, 3, 1'b0, 8'h00, -1, 0, -1);
        finish_test("t1");
        check("t1_count", 32'(out_log.size()), 32'd9);
        if (out_log.size() == 9) begin
            check("t1_first", 32'(out_log[0]), 32'h212);
            check("t1_mid", 32'(out_log[4]), 32'h023);
            check("t1_last", 32'(out_log[8]), 32'h134);
        end

        // 2: swapped corners, line mode
        out_log.delete();
        run_frame(7, 5, 4, 3, 2, 1, 1'b1, 8'h80, -1, 0, -1);
        finish_test("t2");
        check("t2_count", 32'(out_log.size()), 32'd9);
        if (out_log.size() == 9) begin
            check("t2_first", 32'(out_log[0]), 32'h292);
            check("t2_eol1", 32'(out_log[2]), 32'h194);
            check("t2_eol2", 32'(out_log[5]), 32'h1a4);
            check("t2_eol3", 32'(out_log[8]), 32'h1b4);
        end

        // 3: random downstream ready, both tlast modes
        rnd_ready = 1'b1;
        run_frame(7, 5, 2, 1, 4, 3, 1'b0, 8'h40, -1, 0, -1);
        rnd_ready = 1'b1;
        run_frame(7, 5, 0, 5, 7, 0, 1'b1, 8'hc0, -1, 0, -1);
        finish_test("t3");

        // 4: x1 = 8 outside an 8-wide frame, then a valid frame
        out_log.delete();
        run_frame(7, 5, 2, 1, 8, 3, 1'b0, 8'h00, -1, 0, -1);
        idle(4);
        check("t4_bad_count", 32'(out_log.size()), 32'd0);
        run_frame(7, 5, 1, 1, 1, 1, 1'b0, 8'h20, -1, 0, -1);
        finish_test("t4");
        check("t4_single", out_log.size() == 1 ? 32'(out_log[0]) : 32'hffff, 32'h331);

        // 5: line 2 ends at cx = 5
        out_log.delete();
        run_frame(7, 5, 2, 1, 6, 3, 1'b1, 8'h00, 2, 6, -1);
        finish_test("t5");
        check("t5_count", 32'(out_log.size()), 32'd14);
        if (out_log.size() == 14) begin
            check("t5_trunc", 32'(out_log[8]), 32'h025);
            check("t5_next", 32'(out_log[9]), 32'h032);
        end

        // 6: SOF arrives at pixel (3,2) of an active frame
        out_log.delete();
        run_frame(7, 5, 2, 1, 4, 3, 1'b0, 8'h00, -1, 0, 19);
        exp_line++;
        run_frame(7, 5, 5, 4, 1, 0, 1'b1, 8'h40, -1, 0, -1);
        finish_test("t6");
        check("t6_count", 32'(out_log.size()), 32'd29);
        if (out_log.size() == 29) check("t6_restart", 32'(out_log[4]), 32'h241);

        // 7: asynchronous reset mid-frame, then a clean frame
        run_frame(7, 5, 2, 1, 4, 3, 1'b0, 8'h00, -1, 0, 24);
        idle(3);
        #2 arst_i = 1'b1;
        #2 check_reset_outputs("t7_rst");
        @(negedge clk_i);
        arst_i = 1'b0;
        #4;
        check_reset_outputs("t7_post");
        exp_q.delete();
        out_log.delete();
        run_frame(7, 5, 2, 1, 4, 3, 1'b0, 8'h10, -1, 0, -1);
        finish_test("t7");
        check("t7_count", 32'(out_log.size()), 32'd9);
        if (out_log.size() == 9) check("t7_first", 32'(out_log[0]), 32'h202);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish within 500 us");
        $fatal(1);
    end

endmodule
